issue_unit: RTL and testbench

- In-order issue stage sitting directly upstream of the adder reservation-station block.
- Owns the 16x16-bit architectural register file and a per-register tag (register status) table.
- Accepts decoded instructions from fetch, renames operands, and builds the 51-bit station line for the adder (ADD/ADDI/JEQ) or forwards loads to the load unit.
- Snoops the float and load result buses to retire values into the register file, and resolves JEQ branches back to fetch.

---
 rtl/issue_unit_pkg.sv | 77 +++++++
 rtl/issue_unit_reg_status_file.sv | 64 ++++++
 rtl/issue_unit.sv | 153 +++++++++++++++
 tb/tb_issue_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/issue_unit_pkg.sv
`default_nettype none
// ============================================================================
// issue_unit_pkg : opcodes, tags, station-line layout and operand resolution
// Rev 1.0
// ============================================================================
package issue_unit_pkg;

  localparam int NUM_REGS = 16;
  localparam int REG_W    = 4;
  localparam int DATA_W   = 16;
  localparam int LINE_W   = 51;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_LD   = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_JEQ  = 4'd6;

  localparam logic [REG_W-1:0] TAG_NONE    = 4'hF;
  localparam logic [REG_W-1:0] RA_FULL     = 4'hF;
  localparam logic [REG_W-1:0] ADD_TAG_LO  = 4'd0;
  localparam logic [REG_W-1:0] ADD_TAG_HI  = 4'd1;
  localparam logic [REG_W-1:0] LD_TAG_LO   = 4'd8;
  localparam logic [REG_W-1:0] LD_TAG_HI   = 4'd11;

  localparam int LINE_RD_LSB    = 47;
  localparam int LINE_BUSY_BIT  = 46;
  localparam int LINE_OP_LSB    = 42;
  localparam int LINE_V0_LSB    = 26;
  localparam int LINE_RDY0_BIT  = 25;
  localparam int LINE_SRC0_LSB  = 21;
  localparam int LINE_V1_LSB    = 5;
  localparam int LINE_RDY1_BIT  = 4;
  localparam int LINE_SRC1_LSB  = 0;

  typedef enum logic [0:0] {
    ST_ISSUE   = 1'b0,
    ST_WAIT_BR = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic              rdy;
    logic [REG_W-1:0]  src;
  } operand_t;

  // Register file value unless a producer is pending; a same-cycle broadcast
  // of that producer's tag is bypassed straight into the operand.
  function automatic operand_t resolve_operand(
    input logic [REG_W-1:0]  tag,
    input logic [DATA_W-1:0] rf_val,
    input logic              fl_live,
    input logic [REG_W-1:0]  fl_tag,
    input logic [DATA_W-1:0] fl_data,
    input logic              ld_live,
    input logic [REG_W-1:0]  ld_tag,
    input logic [DATA_W-1:0] ld_data
  );
    operand_t op;
    op.val = rf_val;
    op.rdy = 1'b1;
    op.src = TAG_NONE;
    if (tag != TAG_NONE) begin
      if (fl_live && (tag == fl_tag)) begin
        op.val = fl_data;
      end else if (ld_live && (tag == ld_tag)) begin
        op.val = ld_data;
      end else begin
        op.val = '0;
        op.rdy = 1'b0;
        op.src = tag;
      end
    end
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_unit_reg_status_file.sv
`default_nettype none
// ============================================================================
// issue_unit_reg_status_file : 16 regs + producer tags, bus snoop, rename, 2 reads
// Rev 1.0
// ============================================================================
module issue_unit_reg_status_file
  import issue_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_fl_valid,
  input  logic [REG_W-1:0]  i_fl_tag,
  input  logic [DATA_W-1:0] i_fl_data,
  input  logic              i_ld_valid,
  input  logic [REG_W-1:0]  i_ld_tag,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_ren_we,
  input  logic [REG_W-1:0]  i_ren_rd,
  input  logic [REG_W-1:0]  i_ren_tag,
  input  logic [REG_W-1:0]  i_rd_addr0,
  input  logic [REG_W-1:0]  i_rd_addr1,
  output operand_t          o_op0,
  output operand_t          o_op1
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [REG_W-1:0]  r_tags [NUM_REGS];
  logic              w_fl_live;
  logic              w_ld_live;

  // A broadcast of TAG_NONE would otherwise match every settled register.
  assign w_fl_live = i_fl_valid && (i_fl_tag != TAG_NONE);
  assign w_ld_live = i_ld_valid && (i_ld_tag != TAG_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
        r_tags[r] <= TAG_NONE;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_fl_live && (r_tags[r] == i_fl_tag)) r_regs[r] <= i_fl_data;
        if (w_ld_live && (r_tags[r] == i_ld_tag)) r_regs[r] <= i_ld_data;
        // A rename in the retire cycle keeps the newer producer's tag.
        if (i_ren_we && (i_ren_rd == REG_W'(r))) begin
          r_tags[r] <= i_ren_tag;
        end else if ((w_fl_live && (r_tags[r] == i_fl_tag)) ||
                     (w_ld_live && (r_tags[r] == i_ld_tag))) begin
          r_tags[r] <= TAG_NONE;
        end
      end
    end
  end

  assign o_op0 = resolve_operand(r_tags[i_rd_addr0], r_regs[i_rd_addr0],
                                 w_fl_live, i_fl_tag, i_fl_data,
                                 w_ld_live, i_ld_tag, i_ld_data);
  assign o_op1 = resolve_operand(r_tags[i_rd_addr1], r_regs[i_rd_addr1],
                                 w_fl_live, i_fl_tag, i_fl_data,
                                 w_ld_live, i_ld_tag, i_ld_data);

endmodule
`default_nettype wire

// File: rtl/issue_unit.sv
`default_nettype none
// ============================================================================
// issue_unit : in-order issue/rename stage feeding adder RS and load unit
// Rev 1.0
// ============================================================================
module issue_unit
  import issue_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instValid,
  input  logic [15:0]       inst,
  output logic              instReady,
  input  logic [3:0]        nextRA,
  output logic              writeEnabled,
  output logic [LINE_W-1:0] line,
  input  logic              ldSlotFree,
  input  logic [3:0]        ldNextTag,
  output logic              ldValid,
  output logic [15:0]       ldAddr,
  output logic [3:0]        ldRd,
  input  logic              floatOutReady,
  input  logic [15:0]       floatOut,
  input  logic [3:0]        floatOutSrc,
  input  logic              isJeq,
  input  logic              jeqTaken,
  input  logic              loadOutReady,
  input  logic [15:0]       loadOut,
  input  logic [3:0]        loadOutSrc,
  output logic              brResolved,
  output logic              brTaken
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_br_resolved;
  logic             r_br_taken;
  logic             w_br_done;
  logic [3:0]       w_op;
  logic [REG_W-1:0] w_rd;
  logic [REG_W-1:0] w_ra;
  logic [REG_W-1:0] w_rb;
  logic             w_fl_valid;
  logic             w_ren_we;
  logic [REG_W-1:0] w_ren_tag;
  operand_t         w_opa;
  operand_t         w_opb;
  operand_t         w_op1;

  assign {w_op, w_rd, w_ra, w_rb} = inst;
  // Branch results share the float bus but never carry a register value.
  assign w_fl_valid = floatOutReady && !isJeq;

  issue_unit_reg_status_file u_rsf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_fl_valid (w_fl_valid),
    .i_fl_tag   (floatOutSrc),
    .i_fl_data  (floatOut),
    .i_ld_valid (loadOutReady),
    .i_ld_tag   (loadOutSrc),
    .i_ld_data  (loadOut),
    .i_ren_we   (w_ren_we),
    .i_ren_rd   (w_rd),
    .i_ren_tag  (w_ren_tag),
    .i_rd_addr0 (w_ra),
    .i_rd_addr1 (w_rb),
    .o_op0      (w_opa),
    .o_op1      (w_opb)
  );

  assign w_op1 = (w_op == OP_ADDI)
               ? '{val: {{(DATA_W-REG_W){1'b0}}, w_rb}, rdy: 1'b1, src: TAG_NONE}
               : w_opb;

  always_comb begin
    line = '0;
    line[LINE_RD_LSB   +: REG_W]  = w_rd;
    line[LINE_BUSY_BIT]           = 1'b1;
    line[LINE_OP_LSB   +: 4]      = w_op;
    line[LINE_V0_LSB   +: DATA_W] = w_opa.val;
    line[LINE_RDY0_BIT]           = w_opa.rdy;
    line[LINE_SRC0_LSB +: REG_W]  = w_opa.src;
    line[LINE_V1_LSB   +: DATA_W] = w_op1.val;
    line[LINE_RDY1_BIT]           = w_op1.rdy;
    line[LINE_SRC1_LSB +: REG_W]  = w_op1.src;
  end

  assign ldAddr = w_opa.val + {{(DATA_W-REG_W){1'b0}}, w_rb};
  assign ldRd   = w_rd;

  always_comb begin
    w_state_next = r_state;
    instReady    = 1'b0;
    writeEnabled = 1'b0;
    ldValid      = 1'b0;
    w_ren_we     = 1'b0;
    w_ren_tag    = TAG_NONE;
    w_br_done    = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        if (instValid) begin
          case (w_op)
            OP_ADD, OP_ADDI, OP_JEQ: begin
              instReady = (nextRA != RA_FULL);
              if (instReady) begin
                writeEnabled = 1'b1;
                if (w_op == OP_JEQ) begin
                  w_state_next = ST_WAIT_BR;
                end else begin
                  w_ren_we  = 1'b1;
                  w_ren_tag = nextRA;
                end
              end
            end
            OP_LD: begin
              instReady = ldSlotFree && w_opa.rdy;
              if (instReady) begin
                ldValid   = 1'b1;
                w_ren_we  = 1'b1;
                w_ren_tag = ldNextTag;
              end
            end
            default: instReady = 1'b1;
          endcase
        end
      end
      ST_WAIT_BR: begin
        if (floatOutReady && isJeq) begin
          w_br_done    = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_ISSUE;
      r_br_resolved <= 1'b0;
      r_br_taken    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_br_resolved <= w_br_done;
      r_br_taken    <= w_br_done && jeqTaken;
    end
  end

  assign brResolved = r_br_resolved;
  assign brTaken    = r_br_taken;

endmodule
`default_nettype wire

// File: tb/tb_issue_unit.sv
`default_nettype none
// ============================================================================
// tb_issue_unit : directed vector table plus stall / reset-in-branch sequences
// Rev 1.0
// ============================================================================
module tb_issue_unit;

  logic        clk;
  logic        rst_n;
  logic        instValid;
  logic [15:0] inst;
  logic        instReady;
  logic [3:0]  nextRA;
  logic        writeEnabled;
  logic [50:0] line;
  logic        ldSlotFree;
  logic [3:0]  ldNextTag;
  logic        ldValid;
  logic [15:0] ldAddr;
  logic [3:0]  ldRd;
  logic        floatOutReady;
  logic [15:0] floatOut;
  logic [3:0]  floatOutSrc;
  logic        isJeq;
  logic        jeqTaken;
  logic        loadOutReady;
  logic [15:0] loadOut;
  logic [3:0]  loadOutSrc;
  logic        brResolved;
  logic        brTaken;

  int checks   = 0;
  int failures = 0;

  issue_unit dut (
    .clk(clk), .rst_n(rst_n), .instValid(instValid), .inst(inst),
    .instReady(instReady), .nextRA(nextRA), .writeEnabled(writeEnabled),
    .line(line), .ldSlotFree(ldSlotFree), .ldNextTag(ldNextTag),
    .ldValid(ldValid), .ldAddr(ldAddr), .ldRd(ldRd),
    .floatOutReady(floatOutReady), .floatOut(floatOut),
    .floatOutSrc(floatOutSrc), .isJeq(isJeq), .jeqTaken(jeqTaken),
    .loadOutReady(loadOutReady), .loadOut(loadOut), .loadOutSrc(loadOutSrc),
    .brResolved(brResolved), .brTaken(brTaken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        iv;
    logic [15:0] inst;
    logic [3:0]  nra;
    logic        lsf;
    logic [3:0]  lnt;
    logic        fr;
    logic [15:0] fo;
    logic [3:0]  fs;
    logic        ij;
    logic        jt;
    logic        lr;
    logic [15:0] lo;
    logic [3:0]  ls;
    logic        e_ir;
    logic        e_we;
    logic        cl;
    logic [50:0] e_line;
    logic        e_lv;
    logic        cla;
    logic [15:0] e_la;
    logic        e_br;
    logic        e_bt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [50:0] mkl(input logic [3:0] rd, input logic [3:0] op,
                                      input logic [15:0] v0, input logic r0, input logic [3:0] s0,
                                      input logic [15:0] v1, input logic r1, input logic [3:0] s1);
    return {rd, 1'b1, op, v0, r0, s0, v1, r1, s1};
  endfunction

  function automatic vec_t mkv(input string nm, input logic iv, input logic [15:0] in,
                               input logic [3:0] nra, input logic lsf, input logic [3:0] lnt,
                               input logic fr, input logic [15:0] fo, input logic [3:0] fs,
                               input logic ij, input logic jt,
                               input logic lr, input logic [15:0] lo, input logic [3:0] ls,
                               input logic e_ir, input logic e_we, input logic cl, input logic [50:0] el,
                               input logic e_lv, input logic cla, input logic [15:0] ela,
                               input logic e_br, input logic e_bt);
    vec_t v;
    v.name = nm; v.iv = iv; v.inst = in; v.nra = nra; v.lsf = lsf; v.lnt = lnt;
    v.fr = fr; v.fo = fo; v.fs = fs; v.ij = ij; v.jt = jt;
    v.lr = lr; v.lo = lo; v.ls = ls;
    v.e_ir = e_ir; v.e_we = e_we; v.cl = cl; v.e_line = el;
    v.e_lv = e_lv; v.cla = cla; v.e_la = ela; v.e_br = e_br; v.e_bt = e_bt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    instValid = v.iv; inst = v.inst; nextRA = v.nra;
    ldSlotFree = v.lsf; ldNextTag = v.lnt;
    floatOutReady = v.fr; floatOut = v.fo; floatOutSrc = v.fs;
    isJeq = v.ij; jeqTaken = v.jt;
    loadOutReady = v.lr; loadOut = v.lo; loadOutSrc = v.ls;
  endtask

  task automatic idle_inputs();
    instValid = 0; inst = '0; nextRA = 4'hF; ldSlotFree = 0; ldNextTag = 4'h8;
    floatOutReady = 0; floatOut = '0; floatOutSrc = '0; isJeq = 0; jeqTaken = 0;
    loadOutReady = 0; loadOut = '0; loadOutSrc = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [50:0] l_wait;
  logic [50:0] l_r14;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    vecs.push_back(mkv("idle",         1, 16'h0000, 4'hF, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 1, 0, 0, '0, 0, 0, 16'h0, 0, 0));
    vecs[0].iv = 0; vecs[0].e_ir = 0;
    vecs.push_back(mkv("add_r3",       1, 16'h1312, 4'h0, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 1, 1, 1, mkl(4'd3,4'd1,16'h0,1,4'hF,16'h0,1,4'hF), 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("add_r4_dep",   1, 16'h1433, 4'h1, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 1, 1, 1, mkl(4'd4,4'd1,16'h0,0,4'h0,16'h0,0,4'h0), 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("fl_retire_r3", 0, 16'h0000, 4'hF, 0, 4'h8, 1, 16'h0007, 4'h0, 0, 0, 0, 16'h0,    4'h0, 0, 0, 0, '0, 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("peek_r3_r4",   1, 16'h1534, 4'hF, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 0, 0, 1, mkl(4'd5,4'd1,16'h7,1,4'hF,16'h0,0,4'h1), 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("add_r3_again", 1, 16'h1300, 4'h0, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 1, 1, 1, mkl(4'd3,4'd1,16'h0,1,4'hF,16'h0,1,4'hF), 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("bypass_fl",    1, 16'h1531, 4'h1, 0, 4'h8, 1, 16'h0009, 4'h0, 0, 0, 0, 16'h0,    4'h0, 1, 1, 1, mkl(4'd5,4'd1,16'h9,1,4'hF,16'h0,1,4'hF), 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("fl_tag1",      0, 16'h0000, 4'hF, 0, 4'h8, 1, 16'h0010, 4'h1, 0, 0, 0, 16'h0,    4'h0, 0, 0, 0, '0, 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("peek_r4_r5",   1, 16'h1645, 4'hF, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 0, 0, 1, mkl(4'd6,4'd1,16'h10,1,4'hF,16'h10,1,4'hF), 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("ld_issue",     1, 16'h2644, 4'hF, 1, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 1, 0, 0, '0, 1, 1, 16'h0014, 0, 0));
    vecs.push_back(mkv("ld_slot_full", 1, 16'h2741, 4'hF, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 0, 0, 0, '0, 0, 1, 16'h0011, 0, 0));
    vecs.push_back(mkv("ld_bus",       0, 16'h0000, 4'hF, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 1, 16'hBEEF, 4'h8, 0, 0, 0, '0, 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("peek_r6",      1, 16'h1763, 4'hF, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 0, 0, 1, mkl(4'd7,4'd1,16'hBEEF,1,4'hF,16'h9,1,4'hF), 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("addi",         1, 16'h5865, 4'h0, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 1, 1, 1, mkl(4'd8,4'd5,16'hBEEF,1,4'hF,16'h5,1,4'hF), 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("ld_not_ready", 1, 16'h2980, 4'hF, 1, 4'h9, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 0, 0, 0, '0, 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("ld_bypass",    1, 16'h2980, 4'hF, 1, 4'h9, 1, 16'h0100, 4'h0, 0, 0, 0, 16'h0,    4'h0, 1, 0, 0, '0, 1, 1, 16'h0100, 0, 0));
    vecs.push_back(mkv("add_r10",      1, 16'h1A00, 4'h1, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 1, 1, 1, mkl(4'd10,4'd1,16'h0,1,4'hF,16'h0,1,4'hF), 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("both_buses",   0, 16'h0000, 4'hF, 0, 4'h8, 1, 16'h1111, 4'h1, 0, 0, 1, 16'h2222, 4'h9, 0, 0, 0, '0, 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("peek_r10_r9",  1, 16'h1BA9, 4'hF, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 0, 0, 1, mkl(4'd11,4'd1,16'h1111,1,4'hF,16'h2222,1,4'hF), 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("nop",          1, 16'h0123, 4'hF, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 1, 0, 0, '0, 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("add_r13",      1, 16'h1D00, 4'h0, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 1, 1, 1, mkl(4'd13,4'd1,16'h0,1,4'hF,16'h0,1,4'hF), 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("jeq_issue",    1, 16'h6A12, 4'h0, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 1, 1, 1, mkl(4'd10,4'd6,16'h0,1,4'hF,16'h0,1,4'hF), 0, 0, 16'h0, 0, 0));
    l_wait = mkl(4'd12, 4'd1, 16'h0, 0, 4'h0, 16'h0, 1, 4'hF);
    vecs.push_back(mkv("wait_block",   1, 16'h1CD0, 4'h0, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 0, 0, 1, l_wait, 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("jeq_result",   1, 16'h1CD0, 4'h0, 0, 4'h8, 1, 16'hDEAD, 4'h0, 1, 1, 0, 16'h0,    4'h0, 0, 0, 1, l_wait, 0, 0, 16'h0, 0, 0));
    vecs.push_back(mkv("br_pulse",     1, 16'h1CD0, 4'hF, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 0, 0, 1, l_wait, 0, 0, 16'h0, 1, 1));
    vecs.push_back(mkv("br_clear",     1, 16'h1CD0, 4'h2, 0, 4'h8, 0, 16'h0,    4'h0, 0, 0, 0, 16'h0,    4'h0, 1, 1, 1, l_wait, 0, 0, 16'h0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_brResolved", brResolved, 0);
    chk("rst_brTaken", brTaken, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      chk({vecs[i].name, ".instReady"}, instReady, vecs[i].e_ir);
      chk({vecs[i].name, ".writeEnabled"}, writeEnabled, vecs[i].e_we);
      chk({vecs[i].name, ".ldValid"}, ldValid, vecs[i].e_lv);
      chk({vecs[i].name, ".brResolved"}, brResolved, vecs[i].e_br);
      chk({vecs[i].name, ".brTaken"}, brTaken, vecs[i].e_bt);
      if (vecs[i].cl) chk({vecs[i].name, ".line"}, line, vecs[i].e_line);
      if (vecs[i].cla) begin
        chk({vecs[i].name, ".ldAddr"}, ldAddr, vecs[i].e_la);
        chk({vecs[i].name, ".ldRd"}, ldRd, vecs[i].inst[11:8]);
      end
      next_cycle();
    end

    // Station full: ADD r14=r12+r0 held off until a station frees up.
    idle_inputs();
    instValid = 1; inst = 16'h1EC0;
    l_r14 = mkl(4'd14, 4'd1, 16'h0, 0, 4'h2, 16'h0, 1, 4'hF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall.instReady", instReady, 0);
      chk("stall.writeEnabled", writeEnabled, 0);
      chk("stall.line", line, l_r14);
      next_cycle();
    end
    nextRA = 4'h1;
    @(negedge clk);
    chk("unstall.instReady", instReady, 1);
    chk("unstall.writeEnabled", writeEnabled, 1);
    next_cycle();
    inst = 16'h1FE0; nextRA = 4'hF;
    @(negedge clk);
    chk("unstall.tag1", line, mkl(4'd15, 4'd1, 16'h0, 0, 4'h1, 16'h0, 1, 4'hF));
    next_cycle();

    // Reset lands while a branch is outstanding and its result is on the bus.
    inst = 16'h6012; nextRA = 4'h0;
    @(negedge clk);
    chk("rstjeq.accept", instReady, 1);
    next_cycle();
    instValid = 0; floatOutReady = 1; isJeq = 1; jeqTaken = 1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rstjeq.brResolved_in_rst", brResolved, 0);
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("rstjeq.brResolved_after", brResolved, 0);
    chk("rstjeq.brTaken_after", brTaken, 0);
    next_cycle();
    instValid = 1; inst = 16'h1FE6; nextRA = 4'h0;
    @(negedge clk);
    chk("rstjeq.issue_resumes", instReady, 1);
    chk("rstjeq.writeEnabled", writeEnabled, 1);
    chk("rstjeq.regs_cleared", line, mkl(4'd15, 4'd1, 16'h0, 1, 4'hF, 16'h0, 1, 4'hF));
    chk("rstjeq.no_pulse", brResolved, 0);
    next_cycle();
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
